// File: rtl/ram_port_arbiter_if.sv
// Bundle between two requesters, the ram_port_arbiter and the dual-port RAM.
// slave is the arbiter's view; master is the requester/RAM side.
interface ram_port_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              req_a, we_a, gnt_a, rvalid_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a, rdata_a;
  logic              req_b, we_b, gnt_b, rvalid_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b, rdata_b;
  logic              clear_req, busy;
  logic              ram_reset, ram_write_enable, ram_read_enable;
  logic [ADDR_W-1:0] ram_write_address, ram_read_address;
  logic [DATA_W-1:0] ram_data_in, ram_data_out;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a, req_b, we_b, addr_b, wdata_b, clear_req, ram_data_out,
    output gnt_a, rvalid_a, rdata_a, gnt_b, rvalid_b, rdata_b, busy,
    output ram_reset, ram_write_enable, ram_read_enable, ram_write_address, ram_read_address, ram_data_in
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a, req_b, we_b, addr_b, wdata_b, clear_req, ram_data_out,
    input  gnt_a, rvalid_a, rdata_a, gnt_b, rvalid_b, rdata_b, busy,
    input  ram_reset, ram_write_enable, ram_read_enable, ram_write_address, ram_read_address, ram_data_in
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin A/B arbiter in front of the dual-port RAM, with whole-memory clear sequencing.
// Define ARB_STATS_EN to add saturating per-requester grant counters.
module ram_port_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  ram_port_arbiter_if.slave   bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]         grant_cnt_a,
  output logic [15:0]         grant_cnt_b
`endif
);

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        state;
  logic              last_b;
  logic              gnt_a, gnt_b;
  logic              wen, ren, ram_rst;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [DATA_W-1:0] din;
  logic [1:0]        rd_pipe_a, rd_pipe_b;

  // Ties go to whoever did not win last; clear_req pre-empts any grant.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (state == ST_ARB && !bus.clear_req) begin
      gnt_a = bus.req_a & (~bus.req_b | last_b);
      gnt_b = bus.req_b & (~bus.req_a | ~last_b);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_ARB;
      last_b    <= 1'b1;
      wen       <= 1'b0;
      ren       <= 1'b0;
      ram_rst   <= 1'b0;
      waddr     <= '0;
      raddr     <= '0;
      din       <= '0;
      rd_pipe_a <= '0;
      rd_pipe_b <= '0;
    end else begin
      wen       <= 1'b0;
      ren       <= 1'b0;
      ram_rst   <= 1'b0;
      // Tag shifts regardless of state so reads in flight at clear still complete.
      rd_pipe_a <= {rd_pipe_a[0], gnt_a & ~bus.we_a};
      rd_pipe_b <= {rd_pipe_b[0], gnt_b & ~bus.we_b};
      case (state)
        ST_ARB: begin
          if (bus.clear_req) begin
            state   <= ST_CLEAR;
            ram_rst <= 1'b1;
          end else if (gnt_a) begin
            last_b <= 1'b0;
            if (bus.we_a) begin
              wen   <= 1'b1;
              waddr <= bus.addr_a;
              din   <= bus.wdata_a;
            end else begin
              ren   <= 1'b1;
              raddr <= bus.addr_a;
            end
          end else if (gnt_b) begin
            last_b <= 1'b1;
            if (bus.we_b) begin
              wen   <= 1'b1;
              waddr <= bus.addr_b;
              din   <= bus.wdata_b;
            end else begin
              ren   <= 1'b1;
              raddr <= bus.addr_b;
            end
          end
        end
        ST_CLEAR: state <= ST_DRAIN;
        ST_DRAIN: state <= ST_ARB;
        default:  state <= ST_ARB;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt_a <= '0;
      grant_cnt_b <= '0;
    end else if (state == ST_ARB && bus.clear_req) begin
      grant_cnt_a <= '0;
      grant_cnt_b <= '0;
    end else begin
      if (gnt_a && grant_cnt_a != 16'hFFFF) grant_cnt_a <= grant_cnt_a + 16'd1;
      if (gnt_b && grant_cnt_b != 16'hFFFF) grant_cnt_b <= grant_cnt_b + 16'd1;
    end
  end
`endif

  assign bus.gnt_a             = gnt_a;
  assign bus.gnt_b             = gnt_b;
  assign bus.rvalid_a          = rd_pipe_a[1];
  assign bus.rvalid_b          = rd_pipe_b[1];
  assign bus.rdata_a           = bus.ram_data_out;
  assign bus.rdata_b           = bus.ram_data_out;
  assign bus.busy              = (state != ST_ARB);
  assign bus.ram_reset         = ram_rst;
  assign bus.ram_write_enable  = wen;
  assign bus.ram_read_enable   = ren;
  assign bus.ram_write_address = waddr;
  assign bus.ram_read_address  = raddr;
  assign bus.ram_data_in       = din;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 8x256 registered-read RAM.
module tb_ram_port_arbiter;
  logic clk, reset;
  int checks = 0, failures = 0;

  ram_port_arbiter_if #(.DATA_W(8), .ADDR_W(8)) bus ();

`ifdef ARB_STATS_EN
  logic [15:0] cnt_a, cnt_b;
  ram_port_arbiter #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .grant_cnt_a(cnt_a), .grant_cnt_b(cnt_b));
`else
  ram_port_arbiter #(.DATA_W(8), .ADDR_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous clear beats write, write beats read.
  logic [7:0] mem [256];
  logic [7:0] ram_dout;
  always @(posedge clk) begin
    if (bus.ram_reset) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'h00;
      ram_dout <= 8'h00;
    end else if (bus.ram_write_enable) begin
      mem[bus.ram_write_address] <= bus.ram_data_in;
    end else if (bus.ram_read_enable) begin
      ram_dout <= mem[bus.ram_read_address];
    end
  end
  assign bus.ram_data_out = ram_dout;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ra, input logic wa, input logic [7:0] aa, input logic [7:0] da,
                       input logic rb, input logic wb, input logic [7:0] ab, input logic [7:0] db);
    bus.req_a = ra; bus.we_a = wa; bus.addr_a = aa; bus.wdata_a = da;
    bus.req_b = rb; bus.we_b = wb; bus.addr_b = ab; bus.wdata_b = db;
  endtask

  task automatic chk_excl(input string name);
    chk(name, {15'd0, bus.ram_write_enable & bus.ram_read_enable}, 16'd0);
  endtask

  typedef struct {
    logic       ra, wa; logic [7:0] aa, da;
    logic       rb, wb; logic [7:0] ab, db;
    logic       egnt_a, egnt_b, evld_a, evld_b;
    logic [7:0] erd;
  } vec_t;

  vec_t v [16];
  int   rcnt;

  initial begin
    // Each row is one cycle; rvalid expectations land two rows after the read grant.
    v[0]  = '{1'b1,1'b1,8'h10,8'h5A, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h00};
    v[1]  = '{1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h00};
    v[2]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h00};
    v[3]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b1,1'b0,8'h5A};
    v[4]  = '{1'b1,1'b1,8'h01,8'h11, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h00};
    v[5]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h02,8'h22, 1'b0,1'b1,1'b0,1'b0,8'h00};
    v[6]  = '{1'b1,1'b0,8'h01,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h00};
    v[7]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h02,8'h00, 1'b0,1'b1,1'b0,1'b0,8'h00};
    v[8]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b1,1'b0,8'h11};
    v[9]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b1,8'h22};
    v[10] = '{1'b1,1'b0,8'h10,8'h00, 1'b1,1'b1,8'h03,8'h33, 1'b1,1'b0,1'b0,1'b0,8'h00};
    v[11] = '{1'b1,1'b0,8'h02,8'h00, 1'b1,1'b1,8'h03,8'h33, 1'b0,1'b1,1'b0,1'b0,8'h00};
    v[12] = '{1'b1,1'b0,8'h02,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b1,1'b0,8'h5A};
    v[13] = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h03,8'h00, 1'b0,1'b1,1'b0,1'b0,8'h00};
    v[14] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b1,1'b0,8'h22};
    v[15] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b1,8'h33};

    drive(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00);
    bus.clear_req = 1'b0;
    reset = 1'b1;

    // Reset state
    @(negedge clk); #1;
    chk("rst_wen",  {15'd0, bus.ram_write_enable}, 16'd0);
    chk("rst_ren",  {15'd0, bus.ram_read_enable}, 16'd0);
    chk("rst_ramrst", {15'd0, bus.ram_reset}, 16'd0);
    chk("rst_busy", {15'd0, bus.busy}, 16'd0);
    chk("rst_rvalid", {14'd0, bus.rvalid_a, bus.rvalid_b}, 16'd0);
    chk("rst_waddr", {8'd0, bus.ram_write_address}, 16'd0);
    reset = 1'b0;

    // Contention out of reset: A, B, A, B
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1,1'b1,8'h20 + 8'(i),8'(i), 1'b1,1'b0,8'h30,8'h00);
      #1;
      chk($sformatf("cont%0d_gnt_a", i), {15'd0, bus.gnt_a}, {15'd0, ((i % 2) == 0)});
      chk($sformatf("cont%0d_gnt_b", i), {15'd0, bus.gnt_b}, {15'd0, ((i % 2) == 1)});
      chk_excl($sformatf("cont%0d_excl", i));
    end
    @(negedge clk);
    drive(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00);
    chk_excl("cont_tail_excl");
    reset = 1'b1; #1; reset = 1'b0;

    // Table-driven traffic from a fresh reset
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(v[i].ra, v[i].wa, v[i].aa, v[i].da, v[i].rb, v[i].wb, v[i].ab, v[i].db);
      #1;
      chk($sformatf("v%0d_gnt_a", i), {15'd0, bus.gnt_a}, {15'd0, v[i].egnt_a});
      chk($sformatf("v%0d_gnt_b", i), {15'd0, bus.gnt_b}, {15'd0, v[i].egnt_b});
      chk($sformatf("v%0d_rvalid_a", i), {15'd0, bus.rvalid_a}, {15'd0, v[i].evld_a});
      chk($sformatf("v%0d_rvalid_b", i), {15'd0, bus.rvalid_b}, {15'd0, v[i].evld_b});
      if (v[i].evld_a) chk($sformatf("v%0d_rdata_a", i), {8'd0, bus.rdata_a}, {8'd0, v[i].erd});
      if (v[i].evld_b) chk($sformatf("v%0d_rdata_b", i), {8'd0, bus.rdata_b}, {8'd0, v[i].erd});
      chk_excl($sformatf("v%0d_excl", i));
    end

    // Clear with A pending
    @(negedge clk);
    drive(1'b1,1'b1,8'h80,8'hFF, 1'b0,1'b0,8'h00,8'h00);
    #1 chk("clr_wr_gnt", {15'd0, bus.gnt_a}, 16'd1);
    rcnt = 0;
    @(negedge clk);
    drive(1'b1,1'b0,8'h80,8'h00, 1'b0,1'b0,8'h00,8'h00);
    bus.clear_req = 1'b1;
    #1 chk("clr_req_nogrant", {15'd0, bus.gnt_a}, 16'd0);
    chk("clr_req_busy", {15'd0, bus.busy}, 16'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.clear_req = 1'b0;
      #1;
      if (bus.ram_reset) rcnt++;
      chk($sformatf("clr%0d_busy", i), {15'd0, bus.busy}, 16'd1);
      chk($sformatf("clr%0d_ramrst", i), {15'd0, bus.ram_reset}, {15'd0, (i == 0)});
      chk($sformatf("clr%0d_nogrant", i), {15'd0, bus.gnt_a}, 16'd0);
      chk($sformatf("clr%0d_enables", i), {14'd0, bus.ram_write_enable, bus.ram_read_enable}, 16'd0);
`ifdef ARB_STATS_EN
      chk($sformatf("clr%0d_cnt_a", i), cnt_a, 16'd0);
      chk($sformatf("clr%0d_cnt_b", i), cnt_b, 16'd0);
`endif
    end
    @(negedge clk); #1;
    if (bus.ram_reset) rcnt++;
    chk("clr_done_busy", {15'd0, bus.busy}, 16'd0);
    chk("clr_done_gnt", {15'd0, bus.gnt_a}, 16'd1);
    @(negedge clk);
    drive(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00);
    #1 if (bus.ram_reset) rcnt++;
    @(negedge clk); #1;
    if (bus.ram_reset) rcnt++;
    chk("clr_rd_rvalid", {15'd0, bus.rvalid_a}, 16'd1);
    chk("clr_rd_data", {8'd0, bus.rdata_a}, 16'd0);
    chk("clr_ramrst_cycles", 16'(rcnt), 16'd1);

    // Async reset between read grant and rvalid
    @(negedge clk);
    drive(1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h00,8'h00);
    #1 chk("ar_gnt", {15'd0, bus.gnt_a}, 16'd1);
    @(posedge clk); #2;
    chk("ar_pre_ren", {15'd0, bus.ram_read_enable}, 16'd1);
    reset = 1'b1;
    drive(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00);
    #1;
    chk("ar_cmds", {13'd0, bus.ram_write_enable, bus.ram_read_enable, bus.ram_reset}, 16'd0);
    chk("ar_raddr", {8'd0, bus.ram_read_address}, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("ar%0d_rvalid", i), {14'd0, bus.rvalid_a, bus.rvalid_b}, 16'd0);
    end

`ifdef ARB_STATS_EN
    // Stats: A, B, A under contention then A alone; a clear zeroes both
    reset = 1'b1; #1; reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h00,8'h00);
    end
    @(negedge clk);
    drive(1'b1,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00);
    @(negedge clk);
    drive(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00);
    #1;
    chk("st_cnt_a", cnt_a, 16'd3);
    chk("st_cnt_b", cnt_b, 16'd1);
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("st_clr_cnt_a", cnt_a, 16'd0);
    chk("st_clr_cnt_b", cnt_b, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the team's dual-port synchronous RAM (8-bit x 256, registered read, write-over-read priority, synchronous clear).
- Issues at most one access per cycle, never write and read together, and returns read data to the requester that issued the read.
- Owns the RAM's clear input: it sequences a whole-memory clear on request.

Parameters:
- DATA_W, 8, data width; matches the RAM width.
- ADDR_W, 8, address width; matches the RAM address size.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_a  input  1  requester A access request; held until granted.
- we_a  input  1  requester A: 1 = write, 0 = read.
- addr_a  input  ADDR_W  requester A address.
- wdata_a  input  DATA_W  requester A write data.
- gnt_a  output  1  combinational grant to A; command accepted at this edge.
- rvalid_a  output  1  A read data valid, one-cycle pulse.
- rdata_a  output  DATA_W  A read data.
- req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b  same as A, for requester B.
- clear_req  input  1  request a full RAM clear; sampled as a level.
- busy  output  1  high while a clear sequence is in progress.
- ram_reset  output  1  to the RAM's reset input.
- ram_write_enable  output  1  to the RAM's write enable.
- ram_read_enable  output  1  to the RAM's read enable.
- ram_write_address  output  ADDR_W  to the RAM's write address.
- ram_read_address  output  ADDR_W  to the RAM's read address.
- ram_data_in  output  DATA_W  to the RAM's data input.
- ram_data_out  input  DATA_W  from the RAM's data output.

Behaviour:
- Reset (async): FSM=ARB, last_grant=B, all RAM command outputs 0, ram_reset=0, rvalid_a/b=0, rd pipeline tags cleared, busy=0.
- FSM has three states: ARB, CLEAR, DRAIN.
- ARB:
  - If clear_req=1: no grant this cycle; go to CLEAR. clear_req wins over pending requests.
  - Else if only one req is high: grant that requester.
  - Else if both are high: grant the requester that is not last_grant.
  - gnt_x is combinational from FSM, req_a/req_b and last_grant. It is 0 in CLEAR and DRAIN.
- Grant edge N:
  - last_grant <= winner.
  - Write: ram_write_enable<=1, ram_write_address<=addr, ram_data_in<=wdata, ram_read_enable<=0.
  - Read: ram_read_enable<=1, ram_read_address<=addr, ram_write_enable<=0.
  - Both enables are never 1 in the same cycle.
- Idle edge (no grant): both enables <= 0. Address and data registers hold their values.
- Read latency:
  - The command is presented to the RAM in cycle N+1, and the RAM registers data at the end of N+1.
  - rvalid_x is a registered tag delayed 2 edges from the grant, so it is high in cycle N+2.
  - rdata_x = ram_data_out (pass-through) and is only meaningful while rvalid_x=1.
- Back-to-back grants are allowed every cycle. The 2-deep tag pipeline routes each read response independently.
- CLEAR: ram_reset<=1 for exactly one cycle, busy=1, both enables 0, then go to DRAIN.
- DRAIN: ram_reset<=0, busy=1 for one cycle, then go to ARB.
  - Read tags still in flight when CLEAR is entered complete normally; their data predates the clear.
- clear_req held high re-enters CLEAR after DRAIN. Requesters are starved while it stays high; this is by design.
- A requester must hold req/we/addr/wdata stable until gnt is sampled high. Deasserting req before the grant is allowed and drops the request.
- Reset asserted mid-operation aborts all state immediately: in-flight reads produce no rvalid, and ram_reset returns to 0.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt_a and grant_cnt_b, 16 bits each.
  - Each counter increments on every grant to its requester and saturates at 0xFFFF.
  - Both counters are cleared by reset and by entering CLEAR.
- Undefined: the ports and logic are absent. Arbitration behaviour is identical either way.

Test Plan:
- Single write then read, A only:
  - Stimulus: A writes 0x5A at addr 0x10; next cycle A reads 0x10.
  - Required: gnt_a=1 both cycles; rvalid_a high 2 cycles after the read grant with rdata_a=0x5A; rvalid_b never asserts.
- Contention:
  - Stimulus: req_a and req_b held high for 4 cycles out of reset.
  - Required: grant order A, B, A, B; ram_write_enable and ram_read_enable never both 1.
- Interleaved reads:
  - Stimulus: preload 0x01=0x11 and 0x02=0x22; A reads 0x01 and B reads 0x02 on consecutive cycles.
  - Required: rvalid_a with 0x11, then rvalid_b with 0x22 on the next cycle.
- Clear:
  - Stimulus: write 0xFF to 0x80; pulse clear_req with req_a pending.
  - Required: ram_reset high exactly 1 cycle, busy high 2 cycles, no grant during busy; A then granted; a read of 0x80 returns 0x00.
- Async reset mid-read:
  - Stimulus: assert reset between the read grant and rvalid.
  - Required: rvalid stays 0; all RAM command outputs are 0 immediately.
- ARB_STATS_EN:
  - Stimulus: 3 grants to A, 1 grant to B.
  - Required: grant_cnt_a=3, grant_cnt_b=1; both counters read 0 after a clear.
